// File: rtl/fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// fetch_decode_queue
//
// Instruction queue sitting between fetch and decode. Fetch pushes
// (instruction, PC) pairs into a circular buffer; decode sees the oldest pair
// through a valid/ready handshake. A flush drops every queued entry on a
// branch or redirect.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   flush      synchronous discard of all entries (push/pop that cycle ignored)
//   in_valid   fetch presents a pair
//   in_ready   queue can accept a pair (not full); depends on state only
//   in_ir      instruction word from fetch
//   in_pc      PC of that instruction
//   out_valid  head entry valid (not empty)
//   out_ready  decode consumes the head this cycle
//   out_ir     head instruction, 0 when empty
//   out_pc     head PC, 0 when empty
//   count      current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_decode_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_ir,
  input  logic [DATA_W-1:0]          in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_ir,
  output logic [DATA_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fetch_decode_queue: DEPTH must be a power of two and >= 2");
  end

  logic [DATA_W-1:0] r_mem_ir [DEPTH];
  logic [DATA_W-1:0] r_mem_pc [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_empty   = (r_count == '0);
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = !w_empty;
  assign count     = r_count;

  // A flush cancels any handshake in the same cycle, so gate both here.
  assign w_push = in_valid  && in_ready  && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  // Head is a combinational read; forced to zero so an empty queue never
  // shows stale storage to decode.
  assign out_ir = w_empty ? '0 : r_mem_ir[r_rd_ptr];
  assign out_pc = w_empty ? '0 : r_mem_pc[r_rd_ptr];

  // NOTE: storage has no reset; validity is tracked by r_count alone, so
  // clearing the array would only cost reset fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_ir[r_wr_ptr] <= in_ir;
      r_mem_pc[r_wr_ptr] <= in_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;  // idle, or push+pop cancel out
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_decode_queue
//
// Self-checking bench for fetch_decode_queue (DEPTH=4, DATA_W=32): a directed
// vector table, hand-written reset/streaming sequences, and a randomized run
// against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fetch_decode_queue;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_ir;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_ir;
  logic [DATA_W-1:0] out_pc;
  logic [2:0]        count;

  int n_checks = 0;
  int n_errors = 0;

  fetch_decode_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ir     (in_ir),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ir    (out_ir),
    .out_pc    (out_pc),
    .count     (count)
  );

  always #5 clk = ~clk;

  // One row: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] ir;
    logic [31:0] pc;
    int          e_count;
    logic        e_ov;
    logic        e_irdy;
    logic [31:0] e_ir;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
  } pair_t;

  vec_t  vecs[$];
  pair_t model_q[$];

  function automatic vec_t mk(logic f, logic iv, logic ordy, logic [31:0] ir,
                              logic [31:0] pc, int ec, logic eov, logic erdy,
                              logic [31:0] eir, logic [31:0] epc);
    vec_t v;
    v.flush = f; v.in_valid = iv; v.out_ready = ordy; v.ir = ir; v.pc = pc;
    v.e_count = ec; v.e_ov = eov; v.e_irdy = erdy; v.e_ir = eir; v.e_pc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int ec, input logic eov,
                            input logic erdy, input logic [31:0] eir,
                            input logic [31:0] epc);
    check({tag, " count"},     32'(count),     32'(ec));
    check({tag, " out_valid"}, 32'(out_valid), 32'(eov));
    check({tag, " in_ready"},  32'(in_ready),  32'(erdy));
    check({tag, " out_ir"},    out_ir,         eir);
    check({tag, " out_pc"},    out_pc,         epc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ir = '0; in_pc = '0;
  endtask

  // Async reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();

    // ---- reset with no clock edge ----
    #1 rst = 1'b1;
    #1 check_outs("reset_idle", 0, 1'b0, 1'b1, 32'h0, 32'h0);
    #1 rst = 1'b0;
    tick();

    // ---- table: fill/drain, full-with-pop, flush-with-push ----
    vecs.push_back(mk(0,1,0,32'h11,32'h0, 1,1,1,32'h11,32'h0));
    vecs.push_back(mk(0,1,0,32'h22,32'h4, 2,1,1,32'h11,32'h0));
    vecs.push_back(mk(0,1,0,32'h33,32'h8, 3,1,1,32'h11,32'h0));
    vecs.push_back(mk(0,1,0,32'h44,32'hC, 4,1,0,32'h11,32'h0));
    vecs.push_back(mk(0,1,0,32'h55,32'h10,4,1,0,32'h11,32'h0));  // full: dropped
    vecs.push_back(mk(0,0,1,32'h0, 32'h0, 3,1,1,32'h22,32'h4));
    vecs.push_back(mk(0,0,1,32'h0, 32'h0, 2,1,1,32'h33,32'h8));
    vecs.push_back(mk(0,0,1,32'h0, 32'h0, 1,1,1,32'h44,32'hC));
    vecs.push_back(mk(0,0,1,32'h0, 32'h0, 0,0,1,32'h0, 32'h0));
    vecs.push_back(mk(0,0,1,32'h0, 32'h0, 0,0,1,32'h0, 32'h0));  // pop on empty
    vecs.push_back(mk(0,1,0,32'hA0,32'h20,1,1,1,32'hA0,32'h20));
    vecs.push_back(mk(0,1,0,32'hA1,32'h24,2,1,1,32'hA0,32'h20));
    vecs.push_back(mk(0,1,0,32'hA2,32'h28,3,1,1,32'hA0,32'h20));
    vecs.push_back(mk(0,1,0,32'hA3,32'h2C,4,1,0,32'hA0,32'h20));
    vecs.push_back(mk(0,1,1,32'hB0,32'h30,3,1,1,32'hA1,32'h24));  // full: pop only
    vecs.push_back(mk(0,0,1,32'h0, 32'h0, 2,1,1,32'hA2,32'h28));
    vecs.push_back(mk(1,1,0,32'h99,32'h90,0,0,1,32'h0, 32'h0));  // flush + push
    vecs.push_back(mk(0,0,1,32'h0, 32'h0, 0,0,1,32'h0, 32'h0));  // 0x99 gone

    foreach (vecs[i]) begin
      flush     = vecs[i].flush;
      in_valid  = vecs[i].in_valid;
      out_ready = vecs[i].out_ready;
      in_ir     = vecs[i].ir;
      in_pc     = vecs[i].pc;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_ov,
                 vecs[i].e_irdy, vecs[i].e_ir, vecs[i].e_pc);
    end
    idle_inputs();

    // ---- streaming: push and pop every cycle, across pointer wrap ----
    in_valid = 1'b1; out_ready = 1'b1;
    in_ir = 32'h100; in_pc = 32'h1000;
    check("stream pre out_valid", 32'(out_valid), 32'h0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("stream%0d count", k), 32'(count), 32'd1);
      check($sformatf("stream%0d out_ir", k), out_ir, 32'h100 + 32'(k));
      check($sformatf("stream%0d out_pc", k), out_pc, 32'h1000 + 32'(4 * k));
      if (k < 9) begin
        in_ir = 32'h100 + 32'(k + 1);
        in_pc = 32'h1000 + 32'(4 * (k + 1));
      end else begin
        in_valid = 1'b0;
      end
    end
    tick();
    check_outs("stream_end", 0, 1'b0, 1'b1, 32'h0, 32'h0);
    idle_inputs();

    // ---- async reset mid-stream, then cold-start push ----
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_ir = 32'hC0 + 32'(k); in_pc = 32'h80 + 32'(4 * k);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 0, 1'b0, 1'b1, 32'h0, 32'h0);
    #1 rst = 1'b0;
    in_valid = 1'b1; in_ir = 32'hAB; in_pc = 32'h40;
    check("no_bypass out_valid", 32'(out_valid), 32'h0);
    tick();
    in_valid = 1'b0;
    check_outs("after_rst_push", 1, 1'b1, 1'b1, 32'hAB, 32'h40);

    // ---- randomized run against the reference model ----
    idle_inputs();
    pulse_reset();
    model_q.delete();
    tick();
    for (int c = 0; c < 3000; c++) begin
      logic        exp_ov;
      logic        exp_rdy;
      logic [31:0] exp_ir;
      logic [31:0] exp_pc;
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_ir     = $urandom;
      in_pc     = $urandom;
      exp_ov  = (model_q.size() != 0);
      exp_rdy = (model_q.size() != DEPTH);
      exp_ir  = exp_ov ? model_q[0].ir : 32'h0;
      exp_pc  = exp_ov ? model_q[0].pc : 32'h0;
      check_outs($sformatf("rand%0d", c), model_q.size(), exp_ov, exp_rdy,
                 exp_ir, exp_pc);
      tick();
      if (flush) begin
        model_q.delete();
      end else begin
        if (exp_ov && out_ready) void'(model_q.pop_front());
        if (in_valid && exp_rdy) model_q.push_back('{ir: in_ir, pc: in_pc});
      end
    end
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
